// File: rtl/prog_ctr_ras.sv
// Fetch-stage program counter with conditional redirects, a hardware return-address stack,
// and an IDLE/RUN/HALT/FAULT run-control FSM.
module prog_ctr_ras #(
  parameter int unsigned           PC_W       = 10,
  parameter logic [PC_W-1:0]       START_ADDR = '0,
  parameter int unsigned           OFF_W      = 8,
  parameter int unsigned           RAS_DEPTH  = 4,
  localparam int unsigned          CNT_W      = $clog2(RAS_DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_init,
  input  logic             i_bgn,
  input  logic             i_ack,
  input  logic             i_stall,
  input  logic             i_jmp_en,
  input  logic             i_cond,
  input  logic [1:0]       i_jmp_mode,
  input  logic [PC_W-1:0]  i_target,
  input  logic [OFF_W-1:0] i_offset,
  output logic [PC_W-1:0]  o_pgm_ctr,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_ras_cnt,
  output logic             o_ras_full,
  output logic             o_ras_empty
);

  localparam int unsigned IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StHalt  = 2'b10,
    StFault = 2'b11
  } state_e;

  state_e           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic [PC_W-1:0]  r_ras [RAS_DEPTH];

  logic             w_full;
  logic             w_empty;
  logic             w_taken;
  logic             w_push;
  logic [IDX_W-1:0] w_push_idx;
  logic [IDX_W-1:0] w_pop_idx;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_off_ext;
  logic [PC_W-1:0]  w_top;

  always_comb begin
    w_full     = (r_cnt == CNT_W'(RAS_DEPTH));
    w_empty    = (r_cnt == '0);
    w_taken    = i_jmp_en & i_cond;
    w_pc_inc   = r_pc + PC_W'(1);
    w_off_ext  = PC_W'(signed'(i_offset));
    w_push_idx = IDX_W'(r_cnt);
    w_pop_idx  = IDX_W'(r_cnt - CNT_W'(1));
    w_top      = r_ras[w_pop_idx];
    w_push     = (r_state == StRun) & ~i_ack & ~i_stall & w_taken &
                 (i_jmp_mode == 2'b10) & ~w_full;
  end

  // Stack storage needs no reset: entries above r_cnt are never read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_ras[w_push_idx] <= w_pc_inc;
    end
  end

  always_ff @(posedge i_clk or negedge i_init) begin
    if (!i_init) begin
      r_state <= StIdle;
      r_pc    <= START_ADDR;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_bgn) begin
            r_state <= StRun;
            r_pc    <= START_ADDR;
          end
        end
        StRun: begin
          if (i_ack) begin
            r_state <= StHalt;
          end else if (!i_stall) begin
            if (w_taken) begin
              unique case (i_jmp_mode)
                2'b00: r_pc <= i_target;
                2'b01: r_pc <= r_pc + w_off_ext;
                2'b10: begin
                  // Overflowing call leaves PC on the call for debug.
                  if (w_full) begin
                    r_state <= StFault;
                  end else begin
                    r_pc  <= i_target;
                    r_cnt <= r_cnt + CNT_W'(1);
                  end
                end
                default: begin
                  if (w_empty) begin
                    r_state <= StFault;
                  end else begin
                    r_pc  <= w_top;
                    r_cnt <= r_cnt - CNT_W'(1);
                  end
                end
              endcase
            end else begin
              r_pc <= w_pc_inc;
            end
          end
        end
        default: begin
          if (i_bgn) begin
            r_state <= StRun;
            r_pc    <= START_ADDR;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign o_pgm_ctr   = r_pc;
  assign o_state     = r_state;
  assign o_ras_cnt   = r_cnt;
  assign o_ras_full  = w_full;
  assign o_ras_empty = w_empty;

endmodule

// File: tb/tb_prog_ctr_ras.sv
// Self-checking bench for prog_ctr_ras: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_prog_ctr_ras;

  localparam int PC_W  = 10;
  localparam int OFF_W = 8;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << PC_W) - 1;
  localparam int START = 0;

  logic             clk = 1'b0;
  logic             init;
  logic             bgn, ack, stall, jmp_en, cond;
  logic [1:0]       jmp_mode;
  logic [PC_W-1:0]  target;
  logic [OFF_W-1:0] offset;
  logic [PC_W-1:0]  pgm_ctr;
  logic [1:0]       state;
  logic [2:0]       ras_cnt;
  logic             ras_full, ras_empty;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural state only.
  int m_pc;
  int m_state;
  int m_ras[$];

  prog_ctr_ras #(
    .PC_W(PC_W), .START_ADDR(10'(START)), .OFF_W(OFF_W), .RAS_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_init(init), .i_bgn(bgn), .i_ack(ack), .i_stall(stall),
    .i_jmp_en(jmp_en), .i_cond(cond), .i_jmp_mode(jmp_mode), .i_target(target),
    .i_offset(offset), .o_pgm_ctr(pgm_ctr), .o_state(state), .o_ras_cnt(ras_cnt),
    .o_ras_full(ras_full), .o_ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = START;
    m_state = 0;
    m_ras.delete();
  endtask

  task automatic model_step();
    int s;
    if (m_state == 0) begin
      if (bgn) begin m_state = 1; m_pc = START; end
    end else if (m_state == 1) begin
      if (ack) m_state = 2;
      else if (stall) ;
      else if (jmp_en && cond) begin
        case (jmp_mode)
          2'd0: m_pc = int'(target);
          2'd1: begin s = int'($signed(offset)); m_pc = (m_pc + s) & MASK; end
          2'd2: if (m_ras.size() == DEPTH) m_state = 3;
                else begin m_ras.push_back((m_pc + 1) & MASK); m_pc = int'(target); end
          default: if (m_ras.size() == 0) m_state = 3;
                   else m_pc = m_ras.pop_back();
        endcase
      end else m_pc = (m_pc + 1) & MASK;
    end else if (bgn) begin
      m_pc = START; m_ras.delete(); m_state = 1;
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic drive(input logic b, input logic a, input logic s, input logic je,
                       input logic c, input logic [1:0] md, input int tg, input int of);
    bgn = b; ack = a; stall = s; jmp_en = je; cond = c; jmp_mode = md;
    target = PC_W'(tg); offset = OFF_W'(of);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();     drive(0, 0, 0, 0, 0, 2'd0, 0, 0);     endtask
  task automatic jabs(input int t); drive(0, 0, 0, 1, 1, 2'd0, t, 0); endtask
  task automatic jcall(input int t); drive(0, 0, 0, 1, 1, 2'd2, t, 0); endtask
  task automatic jret();    drive(0, 0, 0, 1, 1, 2'd3, 0, 0);     endtask
  task automatic start();   drive(1, 0, 0, 0, 0, 2'd0, 0, 0);     endtask

  task automatic test_reset();
    init = 1'b0;
    bgn = 0; ack = 0; stall = 0; jmp_en = 0; cond = 0; jmp_mode = 0; target = 0; offset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (pgm_ctr !== 10'(START) || state !== 2'd0 || ras_cnt !== 3'd0 ||
        ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: pc=%h st=%0d cnt=%0d e=%b f=%b, want pc=%h st=0 cnt=0 e=1 f=0",
               pgm_ctr, state, ras_cnt, ras_empty, ras_full, START);
    end
    init = 1'b1;
    nop();
    n_tests++;
    if (state !== 2'd0 || pgm_ctr !== 10'(START)) begin
      n_fail++;
      $display("FAIL idle_hold: pc=%h st=%0d, want pc=%h st=0", pgm_ctr, state, START);
    end
  endtask

  task automatic test_start_count();
    start();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (state !== 2'd1 || pgm_ctr !== 10'(START + i)) begin
        n_fail++;
        $display("FAIL count_%0d: pc=%h st=%0d, want pc=%h st=1", i, pgm_ctr, state, START + i);
      end
      nop();
    end
    jabs('h05A);
    #2 init = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (pgm_ctr !== 10'(START) || state !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h st=%0d, want pc=%h st=0", pgm_ctr, state, START);
    end
    @(negedge clk);
    init = 1'b1;
    start();
  endtask

  task automatic test_redirects();
    jabs('h3FF);
    nop();
    n_tests++;
    if (pgm_ctr !== 10'h000) begin
      n_fail++; $display("FAIL wrap: pc=%h, want 000", pgm_ctr);
    end
    jabs('h010);
    drive(0, 0, 0, 1, 1, 2'd1, 0, 'hF0);
    n_tests++;
    if (pgm_ctr !== 10'h000) begin
      n_fail++; $display("FAIL rel_neg: pc=%h, want 000", pgm_ctr);
    end
    jabs('h010);
    drive(0, 0, 0, 1, 0, 2'd0, 'h155, 0);
    n_tests++;
    if (pgm_ctr !== 10'h011) begin
      n_fail++; $display("FAIL cond_false: pc=%h, want 011", pgm_ctr);
    end
    jabs('h2A0);
    n_tests++;
    if (pgm_ctr !== 10'h2A0) begin
      n_fail++; $display("FAIL abs: pc=%h, want 2a0", pgm_ctr);
    end
  endtask

  task automatic test_call_return();
    int exp_pc[3] = '{'h201, 'h101, 'h005};
    jabs('h004);
    jcall('h100);
    jcall('h200);
    jcall('h300);
    n_tests++;
    if (pgm_ctr !== 10'h300 || ras_cnt !== 3'd3) begin
      n_fail++; $display("FAIL call3: pc=%h cnt=%0d, want 300 cnt=3", pgm_ctr, ras_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      jret();
      n_tests++;
      if (pgm_ctr !== 10'(exp_pc[i]) || ras_cnt !== 3'(2 - i)) begin
        n_fail++;
        $display("FAIL ret_%0d: pc=%h cnt=%0d, want %h cnt=%0d", i, pgm_ctr, ras_cnt,
                 exp_pc[i], 2 - i);
      end
    end
  endtask

  task automatic test_overflow_underflow();
    jcall('h010);
    jcall('h020);
    jcall('h030);
    jcall('h050);
    n_tests++;
    if (ras_full !== 1'b1 || ras_cnt !== 3'd4) begin
      n_fail++; $display("FAIL full: f=%b cnt=%0d, want f=1 cnt=4", ras_full, ras_cnt);
    end
    jcall('h123);
    n_tests++;
    if (state !== 2'd3 || pgm_ctr !== 10'h050 || ras_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow: st=%0d pc=%h cnt=%0d, want st=3 pc=050 cnt=4",
               state, pgm_ctr, ras_cnt);
    end
    drive(0, 1, 1, 1, 1, 2'd0, 'h111, 0);
    n_tests++;
    if (state !== 2'd3 || pgm_ctr !== 10'h050) begin
      n_fail++; $display("FAIL fault_hold: st=%0d pc=%h, want st=3 pc=050", state, pgm_ctr);
    end
    start();
    n_tests++;
    if (state !== 2'd1 || pgm_ctr !== 10'(START) || ras_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL restart: st=%0d pc=%h cnt=%0d, want st=1 pc=%h cnt=0",
               state, pgm_ctr, ras_cnt, START);
    end
    jret();
    n_tests++;
    if (state !== 2'd3 || pgm_ctr !== 10'(START) || ras_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: st=%0d pc=%h e=%b, want st=3 pc=%h e=1",
               state, pgm_ctr, ras_empty, START);
    end
    start();
  endtask

  task automatic test_priority();
    jabs('h040);
    jcall('h080);
    drive(0, 0, 1, 1, 1, 2'd2, 'h0F0, 0);
    n_tests++;
    if (pgm_ctr !== 10'h080 || ras_cnt !== 3'd1) begin
      n_fail++; $display("FAIL stall_jmp: pc=%h cnt=%0d, want 080 cnt=1", pgm_ctr, ras_cnt);
    end
    nop();
    n_tests++;
    if (pgm_ctr !== 10'h081 || ras_cnt !== 3'd1) begin
      n_fail++; $display("FAIL no_replay: pc=%h cnt=%0d, want 081 cnt=1", pgm_ctr, ras_cnt);
    end
    drive(0, 1, 1, 1, 1, 2'd0, 'h3C0, 0);
    n_tests++;
    if (state !== 2'd2 || pgm_ctr !== 10'h081) begin
      n_fail++; $display("FAIL ack_prio: st=%0d pc=%h, want st=2 pc=081", state, pgm_ctr);
    end
    drive(0, 1, 0, 1, 1, 2'd0, 'h3C0, 0);
    n_tests++;
    if (state !== 2'd2 || pgm_ctr !== 10'h081 || ras_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL halt_hold: st=%0d pc=%h cnt=%0d, want st=2 pc=081 cnt=1",
               state, pgm_ctr, ras_cnt);
    end
    start();
    n_tests++;
    if (state !== 2'd1 || pgm_ctr !== 10'(START) || ras_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL halt_restart: st=%0d pc=%h cnt=%0d, want st=1 pc=%h cnt=0",
               state, pgm_ctr, ras_cnt, START);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, MASK)), int'($urandom_range(0, 255)));
      n_tests++;
      if (pgm_ctr !== 10'(m_pc) || state !== 2'(m_state) || ras_cnt !== 3'(m_ras.size()) ||
          ras_full !== (m_ras.size() == DEPTH) || ras_empty !== (m_ras.size() == 0)) begin
        n_fail++;
        $display("FAIL random_%0d: pc=%h st=%0d cnt=%0d f=%b e=%b, want pc=%h st=%0d cnt=%0d",
                 i, pgm_ctr, state, ras_cnt, ras_full, ras_empty, m_pc, m_state, m_ras.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_count();
    test_redirects();
    test_call_return();
    test_overflow_underflow();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
